loot_reward_unit: RTL and testbench
===================================

// Module: loot_reward_unit
// PURPOSE
//  Consumes the one-clock caught-loot pulse from the loot map and latches the hooked item.
//  Drives the claw reel speed from the item's weight.
//  Awards the item's value when the claw reports it is home, then keeps level and total scores.
//  Produces a BCD score for the score display and flags when the level target is reached.
// PARAMETERS
//  SCORE_MAX      9999  saturation ceiling for total_score and level_score (14-bit)
//  EMPTY_SPEED    4'd8  reel speed, px/frame, with nothing hooked
//  COMBO_LEN      2'd3  consecutive valuable awards before combo doubling (LOOT_COMBO_EN only)
// PORTS
//  clk              in   1   clock
//  resetN           in   1   reset: asynchronous, active-low
//  start_level      in   1   pulse; clears level state (see BEHAVIOUR)
//  level_target     in   14  level pass score, sampled every cycle
//  caught_loot_type in   3   nonzero for exactly one clk on claw/loot collision
//  hook_home        in   1   pulse; claw fully retracted
//  held_loot_type   out  3   item currently on the hook (0 = none)
//  reel_speed       out  4   px/frame retract speed to claw
//  award_pulse      out  1   one clk when a value is added
//  level_score      out  14  score earned this level
//  total_score      out  14  cumulative score
//  score_bcd        out  16  4 BCD digits of total_score
//  bcd_valid        out  1   score_bcd matches total_score
//  target_reached   out  1   sticky: level_score >= level_target
//  combo_active     out  1   doubling in force (0 when LOOT_COMBO_EN undefined)
// BEHAVIOUR
//  Reset: every output = 0, except reel_speed = EMPTY_SPEED and bcd_valid = 1. FSM in EMPTY_ST.
//  Loot table (type: value/speed): 0 none: 0/EMPTY_SPEED; 1 gold: 100/3; 2 rock: 10/1;
//   3 diamond: 500/6; 4 goblet: 250/4; 5-7 illegal, treated as 0 (ignored).
//  FSM:
//   EMPTY_ST: caught_loot_type!=0 -> latch it; held_loot_type and reel_speed update next clk -> HOLD_ST.
//    hook_home in EMPTY_ST: no award.
//   HOLD_ST: further caught pulses are ignored (one item per hook). hook_home -> AWARD_ST.
//   AWARD_ST (1 clk): level_score and total_score += value, each saturating at SCORE_MAX.
//    award_pulse=1; held_loot_type cleared; reel_speed=EMPTY_SPEED -> EMPTY_ST.
//  Latency: caught pulse @N -> held @N+1; hook_home @M -> award_pulse and scores @M+2.
//  target_reached: set on the clk after level_score >= level_target; sticky until start_level.
//   level_target=0 sets it immediately.
//  start_level (any state, priority over all events in the same clk):
//   level_score=0, target_reached=0, held cleared, FSM -> EMPTY_ST.
//   No award for loot in flight. total_score is kept.
//  BCD: any total_score change starts the converter; bcd_valid=0 until done.
//   An award arriving while the converter is busy sets a pending bit.
//   The converter reruns on completion; score_bcd holds the last good value meanwhile.
// CONFIGURATION
//  LOOT_COMBO_EN defined:
//   2-bit combo counter; +1 on each gold/diamond/goblet award, saturating at COMBO_LEN.
//   A rock award or start_level clears it.
//   When counter==COMBO_LEN at award time, value is doubled before saturation; combo_active = (counter==COMBO_LEN).
//  LOOT_COMBO_EN undefined: no counter logic; combo_active tied 0; values never doubled.
// STRUCTURE
//  Package loot_pkg: loot_t enum (NONE, GOLD, ROCK, DIAMOND, GOBLET);
//   LOOT_VALUE[] and LOOT_SPEED[] constant tables; SCORE_W=14. Shared with the loot map.
//  Sub-module score_bcd_conv: sequential double-dabble, 14 shifts.
//   Ports: start in, bin[13:0] in, busy out, done out, bcd[15:0] out.
// TESTING
//  1 caught=1 @N, hook_home @N+10 -> held=1/speed=3 @N+1; award_pulse @N+12; scores=100; score_bcd=16'h0100 once bcd_valid.
//  2 caught=2 while HOLD gold -> ignored, held stays 1; hook_home in EMPTY_ST -> no award_pulse, scores unchanged.
//  3 total=9900, award diamond -> total_score=9999 (saturated), score_bcd=16'h9999.
//  4 level_target=300: gold x3 -> target_reached after 3rd award; start_level -> level_score=0, target 0, total=300.
//  5 start_level same clk as hook_home while holding diamond -> no award, held=0, speed=EMPTY_SPEED.
//  6 LOOT_COMBO_EN: gold x3 then gold -> 4th award +200, combo_active=1; rock -> +10, combo cleared.

Source files
------------

// File: rtl/loot_pkg.sv
// Shared loot definitions: item codes, value/speed tables and reward FSM states.
// Used by the loot map and the reward unit.
package loot_pkg;

    localparam int unsigned SCORE_W = 14;
    localparam int unsigned VALUE_W = 10;

    typedef enum logic [2:0] {
        NONE    = 3'd0,
        GOLD    = 3'd1,
        ROCK    = 3'd2,
        DIAMOND = 3'd3,
        GOBLET  = 3'd4
    } loot_t;

    typedef enum logic [1:0] {
        EMPTY_ST,
        HOLD_ST,
        AWARD_ST
    } reward_state_t;

    // Codes 5-7 are illegal and carry no value.
    localparam logic [VALUE_W-1:0] LOOT_VALUE [8] = '{
        10'd0, 10'd100, 10'd10, 10'd500, 10'd250, 10'd0, 10'd0, 10'd0
    };

    // Entry 0 is unused; the empty-hook speed is a top-level parameter.
    localparam logic [3:0] LOOT_SPEED [8] = '{
        4'd8, 4'd3, 4'd1, 4'd6, 4'd4, 4'd8, 4'd8, 4'd8
    };

    function automatic logic loot_legal(input logic [2:0] t);
        return (t == GOLD) || (t == ROCK) || (t == DIAMOND) || (t == GOBLET);
    endfunction

    function automatic logic loot_valuable(input logic [2:0] t);
        return (t == GOLD) || (t == DIAMOND) || (t == GOBLET);
    endfunction

endpackage

// File: rtl/loot_reward_unit_if.sv
// Signal bundle between the game logic (master) and the loot reward unit (slave).
interface loot_reward_unit_if;
    import loot_pkg::*;

    logic               start_level;
    logic [SCORE_W-1:0] level_target;
    logic [2:0]         caught_loot_type;
    logic               hook_home;

    logic [2:0]         held_loot_type;
    logic [3:0]         reel_speed;
    logic               award_pulse;
    logic [SCORE_W-1:0] level_score;
    logic [SCORE_W-1:0] total_score;
    logic [15:0]        score_bcd;
    logic               bcd_valid;
    logic               target_reached;
    logic               combo_active;

    modport master (
        output start_level, level_target, caught_loot_type, hook_home,
        input  held_loot_type, reel_speed, award_pulse, level_score, total_score,
               score_bcd, bcd_valid, target_reached, combo_active
    );

    modport slave (
        input  start_level, level_target, caught_loot_type, hook_home,
        output held_loot_type, reel_speed, award_pulse, level_score, total_score,
               score_bcd, bcd_valid, target_reached, combo_active
    );

endinterface

// File: rtl/score_bcd_conv.sv
// Sequential double-dabble: 14-bit binary to 4 BCD digits, one shift per clock.
// bcd holds the last completed result until the next conversion finishes.
module score_bcd_conv (
    input  logic        clk,
    input  logic        resetN,
    input  logic        start,
    input  logic [13:0] bin,
    output logic        busy,
    output logic        done,
    output logic [15:0] bcd
);

    logic [29:0] sh_q;
    logic [3:0]  cnt_q;
    logic        busy_q;
    logic        done_q;
    logic [15:0] bcd_q;
    logic [29:0] sh_nxt;

    // Add-3 on every digit >= 5, then shift the whole register left.
    always_comb begin
        logic [29:0] a;
        a = sh_q;
        for (int d = 0; d < 4; d++) begin
            if (a[14 + 4*d +: 4] >= 4'd5) begin
                a[14 + 4*d +: 4] = a[14 + 4*d +: 4] + 4'd3;
            end
        end
        sh_nxt = {a[28:0], 1'b0};
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sh_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            bcd_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (start && !busy_q) begin
                sh_q   <= {16'd0, bin};
                cnt_q  <= '0;
                busy_q <= 1'b1;
            end else if (busy_q) begin
                sh_q  <= sh_nxt;
                cnt_q <= cnt_q + 4'd1;
                if (cnt_q == 4'd13) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    bcd_q  <= sh_nxt[29:14];
                end
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/loot_reward_unit.sv
// Loot reward unit: latches the hooked item, sets reel speed, awards value when the claw is home,
// keeps saturating level/total scores and a BCD copy. Optional combo doubling: LOOT_COMBO_EN.
module loot_reward_unit
    import loot_pkg::*;
#(
    parameter int unsigned SCORE_MAX   = 9999,
    parameter logic [3:0]  EMPTY_SPEED = 4'd8
`ifdef LOOT_COMBO_EN
    ,
    parameter logic [1:0]  COMBO_LEN   = 2'd3
`endif
) (
    input logic               clk,
    input logic               resetN,
    loot_reward_unit_if.slave bus
);

    localparam logic [SCORE_W-1:0] SCORE_CAP = SCORE_W'(SCORE_MAX);

    reward_state_t      state_q;
    logic [2:0]         held_q;
    logic [3:0]         speed_q;
    logic               award_q;
    logic [SCORE_W-1:0] level_q;
    logic [SCORE_W-1:0] total_q;
    logic               target_q;
    logic               pend_q;
    logic               valid_q;
`ifdef LOOT_COMBO_EN
    logic [1:0]         combo_q;
`endif

    logic [15:0]        award_val;
    logic [15:0]        level_sum;
    logic [15:0]        total_sum;
    logic [SCORE_W-1:0] level_new;
    logic [SCORE_W-1:0] total_new;

    logic               conv_start;
    logic               conv_busy;
    logic               conv_done;
    logic [15:0]        conv_bcd;

    always_comb begin
        award_val = {6'd0, LOOT_VALUE[held_q]};
`ifdef LOOT_COMBO_EN
        if ((combo_q == COMBO_LEN) && loot_valuable(held_q)) begin
            award_val = award_val << 1;
        end
`endif
        level_sum = {2'd0, level_q} + award_val;
        total_sum = {2'd0, total_q} + award_val;
        level_new = (level_sum > {2'd0, SCORE_CAP}) ? SCORE_CAP : level_sum[SCORE_W-1:0];
        total_new = (total_sum > {2'd0, SCORE_CAP}) ? SCORE_CAP : total_sum[SCORE_W-1:0];
    end

    // A total change while the converter is busy waits in pend_q and reruns afterwards.
    assign conv_start = pend_q && !conv_busy;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q  <= EMPTY_ST;
            held_q   <= '0;
            speed_q  <= EMPTY_SPEED;
            award_q  <= 1'b0;
            level_q  <= '0;
            total_q  <= '0;
            target_q <= 1'b0;
            pend_q   <= 1'b0;
            valid_q  <= 1'b1;
`ifdef LOOT_COMBO_EN
            combo_q  <= '0;
`endif
        end else begin
            award_q <= 1'b0;
            if (conv_start) begin
                pend_q <= 1'b0;
            end
            if (conv_done && !pend_q) begin
                valid_q <= 1'b1;
            end

            if (bus.start_level) begin
                state_q  <= EMPTY_ST;
                held_q   <= '0;
                speed_q  <= EMPTY_SPEED;
                level_q  <= '0;
                target_q <= 1'b0;
`ifdef LOOT_COMBO_EN
                combo_q  <= '0;
`endif
            end else begin
                if (level_q >= bus.level_target) begin
                    target_q <= 1'b1;
                end
                unique case (state_q)
                    EMPTY_ST: begin
                        if (loot_legal(bus.caught_loot_type)) begin
                            held_q  <= bus.caught_loot_type;
                            speed_q <= LOOT_SPEED[bus.caught_loot_type];
                            state_q <= HOLD_ST;
                        end
                    end
                    HOLD_ST: begin
                        if (bus.hook_home) begin
                            state_q <= AWARD_ST;
                        end
                    end
                    AWARD_ST: begin
                        award_q <= 1'b1;
                        level_q <= level_new;
                        total_q <= total_new;
                        held_q  <= '0;
                        speed_q <= EMPTY_SPEED;
                        state_q <= EMPTY_ST;
                        if (total_new != total_q) begin
                            pend_q  <= 1'b1;
                            valid_q <= 1'b0;
                        end
`ifdef LOOT_COMBO_EN
                        if (held_q == ROCK) begin
                            combo_q <= '0;
                        end else if (loot_valuable(held_q) && (combo_q != COMBO_LEN)) begin
                            combo_q <= combo_q + 2'd1;
                        end
`endif
                    end
                    default: state_q <= EMPTY_ST;
                endcase
            end
        end
    end

    score_bcd_conv u_bcd (
        .clk    (clk),
        .resetN (resetN),
        .start  (conv_start),
        .bin    (total_q),
        .busy   (conv_busy),
        .done   (conv_done),
        .bcd    (conv_bcd)
    );

    assign bus.held_loot_type = held_q;
    assign bus.reel_speed     = speed_q;
    assign bus.award_pulse    = award_q;
    assign bus.level_score    = level_q;
    assign bus.total_score    = total_q;
    assign bus.score_bcd      = conv_bcd;
    assign bus.bcd_valid      = valid_q;
    assign bus.target_reached = target_q;
`ifdef LOOT_COMBO_EN
    assign bus.combo_active   = (combo_q == COMBO_LEN);
`else
    assign bus.combo_active   = 1'b0;
`endif

endmodule

// File: tb/tb_loot_reward_unit.sv
// Self-checking bench for loot_reward_unit (default build, combo disabled).
module tb_loot_reward_unit;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    always #5 clk = ~clk;

    loot_reward_unit_if bus ();

    loot_reward_unit dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    typedef struct {
        logic [2:0] t;
        logic [2:0] held;
        logic [3:0] speed;
        bit         awarded;
    } vec_t;

    typedef struct {
        int level;
        int total;
    } sb_t;

    int  n_cmp = 0;
    int  n_bad = 0;
    int  exp_level = 0;
    int  exp_total = 0;
    sb_t sb_q[$];
    vec_t vecs[6];

    function automatic int val_of(input logic [2:0] t);
        case (t)
            3'd1:    return 100;
            3'd2:    return 10;
            3'd3:    return 500;
            3'd4:    return 250;
            default: return 0;
        endcase
    endfunction

    function automatic int sat(input int v);
        return (v > 9999) ? 9999 : v;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_caught(input logic [2:0] t);
        bus.caught_loot_type = t;
        tick();
        bus.caught_loot_type = 3'd0;
    endtask

    task automatic push_award(input logic [2:0] t);
        sb_t e;
        exp_level = sat(exp_level + val_of(t));
        exp_total = sat(exp_total + val_of(t));
        e.level = exp_level;
        e.total = exp_total;
        sb_q.push_back(e);
    endtask

    // Returns in the cycle where award_pulse is visible.
    task automatic do_award(input logic [2:0] t);
        pulse_caught(t);
        tick();
        push_award(t);
        bus.hook_home = 1'b1;
        tick();
        bus.hook_home = 1'b0;
        tick();
    endtask

    task automatic wait_bcd(input string nm, input int v);
        int n;
        n = 0;
        while (!bus.bcd_valid && n < 200) begin
            tick();
            n++;
        end
        if (!bus.bcd_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: bcd_valid 0 after %0d cycles, expected 1", nm, n);
        end else begin
            check(nm, 32'(bus.score_bcd), 32'(to_bcd(v)));
        end
    endtask

    // Scoreboard: every award pulse must match the oldest expected award.
    always @(negedge clk) begin
        if (resetN && bus.award_pulse) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL award_unexpected: got award_pulse 1 (total %0d), expected none",
                         bus.total_score);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                check("sb_level", 32'(bus.level_score), 32'(e.level));
                check("sb_total", 32'(bus.total_score), 32'(e.total));
            end
        end
    end

    initial begin
        vecs[0] = '{t: 3'd1, held: 3'd1, speed: 4'd3, awarded: 1'b1};
        vecs[1] = '{t: 3'd2, held: 3'd2, speed: 4'd1, awarded: 1'b1};
        vecs[2] = '{t: 3'd3, held: 3'd3, speed: 4'd6, awarded: 1'b1};
        vecs[3] = '{t: 3'd4, held: 3'd4, speed: 4'd4, awarded: 1'b1};
        vecs[4] = '{t: 3'd5, held: 3'd0, speed: 4'd8, awarded: 1'b0};
        vecs[5] = '{t: 3'd7, held: 3'd0, speed: 4'd8, awarded: 1'b0};

        bus.start_level      = 1'b0;
        bus.level_target     = 14'd16383;
        bus.caught_loot_type = 3'd0;
        bus.hook_home        = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_held", 32'(bus.held_loot_type), 32'd0);
        check("rst_speed", 32'(bus.reel_speed), 32'd8);
        check("rst_award", 32'(bus.award_pulse), 32'd0);
        check("rst_level", 32'(bus.level_score), 32'd0);
        check("rst_total", 32'(bus.total_score), 32'd0);
        check("rst_bcd", 32'(bus.score_bcd), 32'd0);
        check("rst_bcd_valid", 32'(bus.bcd_valid), 32'd1);
        check("rst_target", 32'(bus.target_reached), 32'd0);
        check("rst_combo", 32'(bus.combo_active), 32'd0);
        @(negedge clk);
        resetN = 1'b1;
        tick();

        // 1: gold caught @N, hook_home @N+10, award @N+12
        pulse_caught(3'd1);
        check("t1_held", 32'(bus.held_loot_type), 32'd1);
        check("t1_speed", 32'(bus.reel_speed), 32'd3);
        repeat (9) tick();
        push_award(3'd1);
        bus.hook_home = 1'b1;
        tick();
        bus.hook_home = 1'b0;
        check("t1_award_early", 32'(bus.award_pulse), 32'd0);
        tick();
        check("t1_award", 32'(bus.award_pulse), 32'd1);
        check("t1_held_clr", 32'(bus.held_loot_type), 32'd0);
        check("t1_speed_empty", 32'(bus.reel_speed), 32'd8);
        check("t1_bcd_busy", 32'(bus.bcd_valid), 32'd0);
        wait_bcd("t1_bcd", exp_total);

        // 2: second catch while holding is ignored; hook_home while empty awards nothing
        pulse_caught(3'd1);
        pulse_caught(3'd2);
        check("t2_held_kept", 32'(bus.held_loot_type), 32'd1);
        check("t2_speed_kept", 32'(bus.reel_speed), 32'd3);
        push_award(3'd1);
        bus.hook_home = 1'b1;
        tick();
        bus.hook_home = 1'b0;
        repeat (3) tick();
        bus.hook_home = 1'b1;
        tick();
        bus.hook_home = 1'b0;
        repeat (4) tick();
        check("t2_total_kept", 32'(bus.total_score), 32'(exp_total));

        // Table: each loot code, including illegal ones
        for (int i = 0; i < 6; i++) begin
            pulse_caught(vecs[i].t);
            check($sformatf("vec%0d_held", i), 32'(bus.held_loot_type), 32'(vecs[i].held));
            check($sformatf("vec%0d_speed", i), 32'(bus.reel_speed), 32'(vecs[i].speed));
            tick();
            if (vecs[i].awarded) push_award(vecs[i].t);
            bus.hook_home = 1'b1;
            tick();
            bus.hook_home = 1'b0;
            repeat (2) tick();
            check($sformatf("vec%0d_total", i), 32'(bus.total_score), 32'(exp_total));
            check($sformatf("vec%0d_speed_after", i), 32'(bus.reel_speed), 32'd8);
        end
        wait_bcd("vec_bcd", exp_total);

        // 4: level target and start_level
        bus.start_level = 1'b1;
        tick();
        bus.start_level = 1'b0;
        exp_level = 0;
        check("t4_level_clr", 32'(bus.level_score), 32'd0);
        bus.level_target = 14'd300;
        do_award(3'd1);
        tick();
        check("t4_tgt_1", 32'(bus.target_reached), 32'd0);
        do_award(3'd1);
        tick();
        check("t4_tgt_2", 32'(bus.target_reached), 32'd0);
        do_award(3'd1);
        check("t4_tgt_same_clk", 32'(bus.target_reached), 32'd0);
        tick();
        check("t4_tgt_set", 32'(bus.target_reached), 32'd1);
        repeat (3) tick();
        check("t4_tgt_sticky", 32'(bus.target_reached), 32'd1);
        bus.start_level = 1'b1;
        tick();
        bus.start_level = 1'b0;
        exp_level = 0;
        check("t4_level_new", 32'(bus.level_score), 32'd0);
        check("t4_tgt_clr", 32'(bus.target_reached), 32'd0);
        check("t4_total_kept", 32'(bus.total_score), 32'(exp_total));
        bus.level_target = 14'd0;
        tick();
        check("t4_tgt_zero", 32'(bus.target_reached), 32'd1);
        bus.level_target = 14'd16383;
        bus.start_level = 1'b1;
        tick();
        bus.start_level = 1'b0;
        check("t4_tgt_clr2", 32'(bus.target_reached), 32'd0);

        // 5: start_level in the same clock as hook_home while holding a diamond
        pulse_caught(3'd3);
        check("t5_held", 32'(bus.held_loot_type), 32'd3);
        tick();
        bus.hook_home = 1'b1;
        bus.start_level = 1'b1;
        tick();
        bus.hook_home = 1'b0;
        bus.start_level = 1'b0;
        check("t5_held_clr", 32'(bus.held_loot_type), 32'd0);
        check("t5_speed", 32'(bus.reel_speed), 32'd8);
        repeat (4) tick();
        check("t5_level", 32'(bus.level_score), 32'd0);
        check("t5_total", 32'(bus.total_score), 32'(exp_total));

        // 3: climb to 9900 (awards overlap the converter), then saturate with a diamond
        while (exp_total + 500 <= 9900) do_award(3'd3);
        while (exp_total < 9900) do_award(3'd2);
        tick();
        check("t3_total_9900", 32'(bus.total_score), 32'd9900);
        wait_bcd("t3_bcd_9900", 9900);
        do_award(3'd3);
        check("t3_total_sat", 32'(bus.total_score), 32'd9999);
        check("t3_level", 32'(bus.level_score), 32'(exp_level));
        check("t3_combo", 32'(bus.combo_active), 32'd0);
        wait_bcd("t3_bcd_sat", 9999);
        do_award(3'd4);
        tick();
        check("t3_total_hold", 32'(bus.total_score), 32'd9999);
        check("t3_valid_hold", 32'(bus.bcd_valid), 32'd1);

        repeat (3) tick();
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
